// File: rtl/reg_pipe_pkg.sv
// rtl/reg_pipe_pkg.sv - shared helpers for the register pipeline
package reg_pipe_pkg;

    // Bits needed to hold an occupancy count of 0..depth
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_if.sv
// rtl/reg_pipe_if.sv - producer/consumer handshake bundle for the register pipeline
interface reg_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    import reg_pipe_pkg::*;

    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] d_in;
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] q_out;
    logic             valid_out;
    logic             ready_in;
    logic             flush_in;
    logic [CW-1:0]    count_out;

    modport master (
        output d_in, valid_in, ready_in, flush_in,
        input  ready_out, q_out, valid_out, count_out
    );

    modport slave (
        input  d_in, valid_in, ready_in, flush_in,
        output ready_out, q_out, valid_out, count_out
    );

endinterface

// File: rtl/reg_pipe_stage.sv
// rtl/reg_pipe_stage.sv - one data register plus valid bit with load/drain/clear
module reg_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             v
);

    // Load wins over drain so a word can leave and be replaced in one cycle;
    // clear drops the valid bit but keeps the stale data register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q <= RESET_VAL;
            v <= 1'b0;
        end else if (clear) begin
            v <= 1'b0;
        end else if (load) begin
            q <= d;
            v <= 1'b1;
        end else if (drain) begin
            v <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// rtl/reg_pipe.sv - bubble-collapsing valid/ready register pipeline
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic       clk_in,
    input  logic       n_rst_in,
    reg_pipe_if.slave  bus
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] data [DEPTH];
    logic             take;
    logic             take0;
    logic             in_xfer;
    logic             out_xfer;
    logic [CW-1:0]    count_q;

    // Ready chain walked from the output end: a stage advances when the next
    // one is empty or itself advancing, so bubbles always get filled.
    always_comb begin
        adv   = '0;
        take  = bus.ready_in;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = v[i] & take;
            take   = !v[i] | adv[i];
        end
        take0 = take;
    end

    assign bus.ready_out = take0 & !bus.flush_in;
    assign in_xfer       = bus.valid_in & bus.ready_out;
    assign out_xfer      = v[DEPTH-1] & bus.ready_in;
    assign bus.valid_out = v[DEPTH-1];
    assign bus.q_out     = data[DEPTH-1];
    assign bus.count_out = count_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             stage_load;
        logic [WIDTH-1:0] stage_d;

        if (i == 0) begin : g_first
            assign stage_load = in_xfer;
            assign stage_d    = bus.d_in;
        end else begin : g_rest
            assign stage_load = adv[i-1];
            assign stage_d    = data[i-1];
        end

        reg_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk    (clk_in),
            .resetn (n_rst_in),
            .clear  (bus.flush_in),
            .load   (stage_load),
            .drain  (adv[i]),
            .d      (stage_d),
            .q      (data[i]),
            .v      (v[i])
        );
    end

    // Occupancy tracked incrementally; equals the popcount of the valid bits
    // after every edge since only one word can enter and one leave per cycle.
    always_ff @(posedge clk_in) begin
        if (!n_rst_in) begin
            count_q <= '0;
        end else if (bus.flush_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(in_xfer) - CW'(out_xfer);
        end
    end

endmodule

// File: tb/tb_reg_pipe.sv
// tb/tb_reg_pipe.sv - scoreboard bench for the register pipeline
module tb_reg_pipe;

    localparam int         W  = 8;
    localparam int         D  = 4;
    localparam logic [7:0] RV = 8'h5A;

    typedef struct {
        logic [7:0] data;
        int         stamp;
    } entry_t;

    logic   clk = 1'b0;
    logic   n_rst;
    int     now = 0;
    int     tests = 0;
    int     fails = 0;
    bit     mon_en = 1'b0;
    bit     rst_seen = 1'b0;
    entry_t sb[$];

    reg_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();

    reg_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
        .clk_in   (clk),
        .n_rst_in (n_rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) now <= now + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, now);
        end
    endtask

    // Reference: an in-order FIFO of capacity D. The oldest word moves one
    // stage per edge until it reaches the output, so it is visible once
    // D-1 edges have passed since its acceptance.
    always @(negedge clk) begin
        logic exp_v;
        logic exp_r;
        if (mon_en) begin
            exp_v = (sb.size() > 0) && (now - sb[0].stamp >= D - 1);
            exp_r = !bus.flush_in && ((sb.size() < D) || bus.ready_in);
            check("count_out", 32'(bus.count_out), 32'(sb.size()));
            check("valid_out", 32'(bus.valid_out), 32'(exp_v));
            check("ready_out", 32'(bus.ready_out), 32'(exp_r));
            if (exp_v) check("q_out", 32'(bus.q_out), 32'(sb[0].data));
            if (rst_seen) check("q_out_reset", 32'(bus.q_out), 32'(RV));
            rst_seen = 1'b0;
            if (!n_rst) begin
                sb.delete();
                rst_seen = 1'b1;
            end else begin
                if (exp_v && bus.ready_in) void'(sb.pop_front());
                if (bus.flush_in) sb.delete();
                else if (bus.valid_in && exp_r) sb.push_back(entry_t'{bus.d_in, now + 1});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vi, input logic [7:0] d, input logic ri, input logic fl);
        bus.valid_in = vi;
        bus.d_in     = d;
        bus.ready_in = ri;
        bus.flush_in = fl;
    endtask

    initial begin
        logic [7:0] pat [3];
        n_rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        tick();
        n_rst = 1'b1;

        // stream three words with no backpressure
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pat[i], 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (8) tick();

        // fill under backpressure, offering more than fits
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) tick();

        // simultaneous in/out on a full pipe, then drain
        drive(1'b1, 8'hB0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (6) tick();

        // bubble collapse with a stalled output
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) tick();
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (5) tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (6) tick();

        // flush with a word offered in the same cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'hFF, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (6) tick();

        // synchronous reset on a full pipe
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();

        // a reset glitch between edges must be ignored
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1 n_rst = 1'b0;
        #2 n_rst = 1'b1;
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (6) tick();

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
            n_rst = 1'($urandom_range(0, 150) != 0);
            tick();
        end
        n_rst = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (8) tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
